// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end: issues sequential fetches to a one-cycle-latency
// instruction memory, tags each returned word with its address and hands it
// downstream through an output stage backed by a one-entry skid buffer.
// A taken-branch pulse redirects fetch and flushes everything in flight.
//
// Optional feature (macro FETCH_BRANCH_HOLD_EN): when defined, a returned word
// with bits[1:0] == 2'b10 is treated as a branch, and fetching pauses in
// BRANCH_WAIT until branch_resolve. When undefined, fetch predicts not-taken
// and branch_resolve is ignored.
//
// Ports:
//   clk            in   clock, all state on the rising edge
//   rst_n          in   asynchronous active-low reset
//   imem_addr      out  [11:0] fetch address (current pc)
//   imem_req       out  fetch request; imem_rdata valid the following cycle
//   imem_rdata     in   [15:0] instruction word from memory
//   stall          in   downstream not accepting
//   branch_res     in   taken-branch pulse
//   new_pc         in   [11:0] branch target, used with branch_res
//   branch_resolve in   resolution pulse for the outstanding branch
//   if_instruction out  [15:0] instruction handed downstream
//   if_pc          out  [11:0] address of if_instruction
//   if_valid       out  if_instruction/if_pc valid
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [11:0] imem_addr,
    output logic        imem_req,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_res,
    input  logic [11:0] new_pc,
    input  logic        branch_resolve,
    output logic [15:0] if_instruction,
    output logic [11:0] if_pc,
    output logic        if_valid
);

    typedef enum logic [1:0] {IDLE, RUN, BRANCH_WAIT} state_t;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic        resp_pending_q, resp_pending_d;
    logic [11:0] resp_pc_q, resp_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_instr_q, out_instr_d;
    logic [11:0] out_pc_q, out_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [11:0] skid_pc_q, skid_pc_d;

    logic accept;
    logic consume;
    logic hold_cancel;

    // A response returning in a redirect cycle belongs to the wrong path.
    assign accept = resp_pending_q & ~branch_res;

`ifdef FETCH_BRANCH_HOLD_EN
    assign hold_cancel = accept && (state_q == RUN) && (imem_rdata[1:0] == 2'b10);
`else
    logic unused_resolve;
    assign hold_cancel    = 1'b0;
    assign unused_resolve = branch_resolve;
`endif

    // The output stage shows the held register if occupied, otherwise the
    // response arriving this cycle directly, so a fetch is visible the cycle
    // its data returns.
    assign if_valid       = out_valid_q | accept;
    assign if_instruction = out_valid_q ? out_instr_q : (accept ? imem_rdata : 16'h0000);
    assign if_pc          = out_valid_q ? out_pc_q    : (accept ? resp_pc_q  : 12'h000);
    assign consume        = if_valid & ~stall;

    assign imem_req  = (state_q == RUN) & ~stall & ~skid_valid_q & ~hold_cancel;
    assign imem_addr = pc_q;

    // State machine
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        state_d = RUN;
            RUN:         if (hold_cancel) state_d = BRANCH_WAIT;
`ifdef FETCH_BRANCH_HOLD_EN
            BRANCH_WAIT: if (branch_resolve) state_d = RUN;
`else
            BRANCH_WAIT: state_d = RUN;
`endif
            default:     state_d = IDLE;
        endcase
    end

    // Program counter and in-flight response tracking
    always_comb begin
        pc_d           = pc_q;
        resp_pending_d = imem_req & ~branch_res;
        resp_pc_d      = pc_q;
        if (branch_res) begin
            pc_d = new_pc;
        end else if (imem_req) begin
            pc_d = pc_q + 12'd1;
        end
    end

    // Output register and skid buffer
    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (branch_res) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_valid_q) begin
            if (consume) begin
                if (skid_valid_q) begin
                    out_instr_d  = skid_instr_q;
                    out_pc_d     = skid_pc_q;
                    skid_valid_d = accept;
                    skid_instr_d = imem_rdata;
                    skid_pc_d    = resp_pc_q;
                end else if (accept) begin
                    out_instr_d = imem_rdata;
                    out_pc_d    = resp_pc_q;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = resp_pc_q;
            end
        end else if (accept && stall) begin
            // Live response not taken this cycle: capture it so it stays put.
            out_valid_d = 1'b1;
            out_instr_d = imem_rdata;
            out_pc_d    = resp_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            resp_pending_q <= 1'b0;
            resp_pc_q      <= 12'h000;
            out_valid_q    <= 1'b0;
            out_instr_q    <= 16'h0000;
            out_pc_q       <= 12'h000;
            skid_valid_q   <= 1'b0;
            skid_instr_q   <= 16'h0000;
            skid_pc_q      <= 12'h000;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            resp_pending_q <= resp_pending_d;
            resp_pc_q      <= resp_pc_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_pc_q       <= out_pc_d;
            skid_valid_q   <= skid_valid_d;
            skid_instr_q   <= skid_instr_d;
            skid_pc_q      <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed steps followed by a randomized phase. A stream-level reference
// model expects delivered instructions to be consecutive addresses starting at
// the reset pc and restarting at each taken-branch target, each carrying the
// memory word for its address, and the output to stay frozen while stalled.
// A second instance with RESET_PC=12'hFFE covers the wrap-around start.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_res = 1'b0;
    logic [11:0] new_pc = 12'h000;
    logic        branch_resolve = 1'b0;

    logic [11:0] imem_addr, if_pc;
    logic        imem_req, if_valid;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] if_instruction;

    logic [11:0] imem_addr2, if_pc2;
    logic        imem_req2, if_valid2;
    logic [15:0] imem_rdata2 = 16'h0000;
    logic [15:0] if_instruction2;

    logic        hold_word_en = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic [11:0] exp_pc = 12'h000;
    logic        prev_hold = 1'b0;
    logic [11:0] prev_pc = 12'h000;
    logic [15:0] prev_instr = 16'h0000;
    int          consumes = 0;

    fetch_unit #(.RESET_PC(12'h000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .stall(stall), .branch_res(branch_res),
        .new_pc(new_pc), .branch_resolve(branch_resolve),
        .if_instruction(if_instruction), .if_pc(if_pc), .if_valid(if_valid)
    );

    fetch_unit #(.RESET_PC(12'hFFE)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_req(imem_req2),
        .imem_rdata(imem_rdata2), .stall(stall), .branch_res(branch_res),
        .new_pc(new_pc), .branch_resolve(branch_resolve),
        .if_instruction(if_instruction2), .if_pc(if_pc2), .if_valid(if_valid2)
    );

    function automatic logic [15:0] mem_word(input logic [11:0] a);
        if (hold_word_en && a == 12'd3) return 16'h0012;
        return {a, 4'h1};
    endfunction

    // One-cycle-latency memories
    always @(posedge clk) begin
        if (imem_req)  imem_rdata  <= mem_word(imem_addr);
        if (imem_req2) imem_rdata2 <= {imem_addr2, 4'h1};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total = n_total + 1;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic model_step();
        if (!rst_n) begin
            chk("rst_valid", {31'd0, if_valid}, 32'd0);
            exp_pc    = 12'h000;
            prev_hold = 1'b0;
            return;
        end
        if (prev_hold) begin
            chk("hold_valid", {31'd0, if_valid}, 32'd1);
            chk("hold_pc", {20'd0, if_pc}, {20'd0, prev_pc});
            chk("hold_instr", {16'd0, if_instruction}, {16'd0, prev_instr});
        end
        chk("req_vs_stall", {31'd0, imem_req & stall}, 32'd0);
        if (if_valid && !stall) begin
            chk("stream_pc", {20'd0, if_pc}, {20'd0, exp_pc});
            chk("stream_instr", {16'd0, if_instruction}, {16'd0, mem_word(exp_pc)});
            exp_pc   = exp_pc + 12'd1;
            consumes = consumes + 1;
        end
        prev_hold  = if_valid && stall && !branch_res;
        prev_pc    = if_pc;
        prev_instr = if_instruction;
        if (branch_res) exp_pc = new_pc;
    endtask

    task automatic cyc(input logic r, input logic s, input logic br,
                       input logic [11:0] npc, input logic res);
        @(negedge clk);
        rst_n          = r;
        stall          = s;
        branch_res     = br;
        new_pc         = npc;
        branch_resolve = res;
        #1;
        model_step();
    endtask

    initial begin
        int cons_start;

        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr", {16'd0, if_instruction}, 32'd0);
        chk("rst_ifpc", {20'd0, if_pc}, 32'd0);
        chk("rst_addr", {20'd0, imem_addr}, 32'd0);
        chk("rst_addr2", {20'd0, imem_addr2}, 32'hFFE);
        cyc(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);

        // Start-up latency
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("c1_req", {31'd0, imem_req}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("c2_req", {31'd0, imem_req}, 32'd1);
        chk("c2_addr", {20'd0, imem_addr}, 32'd0);
        chk("c2_valid", {31'd0, if_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
            chk("seq_valid", {31'd0, if_valid}, 32'd1);
            chk("seq_pc", {20'd0, if_pc}, i);
            chk("wrap_pc", {20'd0, if_pc2}, {20'd0, 12'hFFE + 12'(i)});
        end
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);

        // Stall for three cycles on pc 5
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 12'h0, 1'b0);
            chk("stall_pc", {20'd0, if_pc}, 32'd5);
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("release_pc", {20'd0, if_pc}, 32'd5);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
            chk("after_stall_pc", {20'd0, if_pc}, 32'd6 + i);
        end

        // Redirect to 12'h040
        cyc(1'b1, 1'b0, 1'b1, 12'h040, 1'b0);
        chk("br_n_valid", {31'd0, if_valid}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("br_n1_addr", {20'd0, imem_addr}, 32'h040);
        chk("br_n1_req", {31'd0, imem_req}, 32'd1);
        chk("br_n1_valid", {31'd0, if_valid}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("br_n2_valid", {31'd0, if_valid}, 32'd1);
        chk("br_n2_pc", {20'd0, if_pc}, 32'h040);

        // Reset pulse mid-stream while stalled
        cyc(1'b1, 1'b1, 1'b0, 12'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 12'h0, 1'b0);
        chk("pre_rst_valid", {31'd0, if_valid}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 12'h0, 1'b0);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_instr", {16'd0, if_instruction}, 32'd0);
        chk("midrst_addr", {20'd0, imem_addr}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("restart_addr", {20'd0, imem_addr}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("restart_pc", {20'd0, if_pc}, 32'd0);
        chk("restart_valid", {31'd0, if_valid}, 32'd1);

`ifdef FETCH_BRANCH_HOLD_EN
        // Branch hold: word 16'h0012 at pc 3
        hold_word_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("hold_br_pc", {20'd0, if_pc}, 32'd3);
        chk("hold_br_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
            chk("hold_wait_req", {31'd0, imem_req}, 32'd0);
        end
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        chk("resume_addr", {20'd0, imem_addr}, 32'd4);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("resume_pc", {20'd0, if_pc}, 32'd4);
        cyc(1'b1, 1'b0, 1'b1, 12'd3, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("hold2_pc", {20'd0, if_pc}, 32'd3);
        chk("hold2_req", {31'd0, imem_req}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("hold2_wait_req", {31'd0, imem_req}, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 12'd9, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("taken_addr", {20'd0, imem_addr}, 32'd9);
        chk("taken_req", {31'd0, imem_req}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        chk("taken_pc", {20'd0, if_pc}, 32'd9);
        hold_word_en = 1'b0;
`endif

        // Randomized stall / redirect traffic against the stream model
        cons_start = consumes;
        for (int i = 0; i < 400; i++) begin
            logic        s, br, res;
            logic [11:0] npc;
            s   = ($urandom_range(0, 9) < 3);
            br  = ($urandom_range(0, 19) == 0);
            npc = ($urandom_range(0, 3) == 0) ? 12'hFFD : 12'($urandom_range(0, 4095));
            res = ($urandom_range(0, 7) == 0);
            cyc(1'b1, s, br, npc, res);
        end
        chk("random_progress", {31'd0, (consumes - cons_start) > 100}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
